seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Scan controller for the 8-digit multiplexed seven-segment display. It divides the system clock into the pixel-clock tick and advances the 3-bit digit select on each tick. It drives active-low anodes, the hex nibble and the decimal point for the selected digit. It double-buffers a 32-bit display word so updates land only at frame boundaries, and it optionally blanks leading zeros.

Parameters:
DIV_COUNT, 50000, clk cycles per pxl_clk tick (>=2)
GUARD, 2, clk cycles all anodes forced off after each digit change (0 <= GUARD < DIV_COUNT)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
wr_en  input  1  one-cycle write strobe for a new display word
wr_data  input  32  8 hex nibbles; nibble i ([4i+3:4i]) belongs to digit i
dp_in  input  8  decimal-point enables per digit (1 = lit); sampled with wr_data
blank_lz  input  1  leading-zero blanking enable (live, not buffered)
pxl_clk  output  1  one-cycle tick every DIV_COUNT clocks
seq_sel  output  3  current digit index 0..7
an  output  8  anode drives, active-low, one-hot-zero
hex_nib  output  4  nibble for digit seq_sel
dp_n  output  1  decimal point, active-low
wr_ack  output  1  one-cycle pulse when a pending word is committed

Behaviour:
- One clock, clk. Reset is asynchronous and active-high. All state is cleared on reset assertion, independent of clk.
- Reset values: div_cnt=0, pxl_clk=0, seq_sel=0, state=S_GUARD, guard_cnt=GUARD, an=8'hFF, hex_nib=0, dp_n=1, wr_ack=0, disp_reg=0, dp_reg=0, pend_valid=0.
- Divider: div_cnt counts 0..DIV_COUNT-1 and wraps. pxl_clk is registered and is high for exactly the cycle after div_cnt==DIV_COUNT-1. The first tick therefore occurs DIV_COUNT cycles after reset release.
- In a pxl_clk cycle, seq_sel increments mod 8 (7 wraps to 0).
- FSM states:
  - S_GUARD: an=8'hFF; guard_cnt decrements each cycle. Go to S_DRIVE when guard_cnt==0. If GUARD=0, S_GUARD is skipped.
  - S_DRIVE: an[seq_sel]=0 unless the digit is blanked.
  - On every pxl_clk cycle, from either state, go to S_GUARD and reload guard_cnt=GUARD.
- hex_nib = disp_reg nibble[seq_sel]. dp_n = ~dp_reg[seq_sel]. Both are valid in both states.
- Write buffering:
  - wr_en loads pend_word and pend_dp and sets pend_valid.
  - A further write before commit overwrites the pending word (last write wins) and produces only one ack.
- Commit:
  - Occurs on the pxl_clk cycle where seq_sel goes 7->0, if pend_valid or wr_en is set that cycle.
  - A wr_en on the commit cycle bypasses the pending register: wr_data is committed directly.
  - Commit writes disp_reg/dp_reg, clears pend_valid, and pulses wr_ack in the following cycle.
  - The new word is first visible at seq_sel=0.
- Leading-zero blanking: digit i (1..7) is blanked when blank_lz=1 and nibbles i..7 of disp_reg are all 0. Digit 0 is never blanked. A blanked digit keeps an=8'hFF and forces dp_n=1 unless dp_reg[i]=1; a lit dp un-blanks that digit.
- Reset mid-frame discards the pending word; no wr_ack is emitted.
- an is never more than one bit low in any cycle.

Decomposition:
- Shared package seg_pkg:
  - state encoding (S_GUARD, S_DRIVE)
  - NUM_DIGITS=8
  - SEL_W=3
  - ANODES_OFF=8'hFF
- One natural sub-module, tick_div: the DIV_COUNT divider producing pxl_clk.
- Scan FSM, buffering and blanking stay in seg_scan_ctrl.

Test Plan (DIV_COUNT=4, GUARD=1):
- Reset released, no writes -> pxl_clk every 4 clocks; seq_sel 0,1,...,7,0. In S_GUARD, an=FF. In S_DRIVE, an=~(1<<seq_sel). hex_nib=0 throughout.
- wr_en with 32'h1234ABCD, dp_in=8'h01, mid-frame -> no visible change until the 7->0 wrap; wr_ack 1 cycle after wrap. At seq_sel=0: hex_nib=D, dp_n=0, an=FE after 1 guard cycle. At seq_sel=7: hex_nib=1, an=7F.
- Two writes (32'h11111111, then 32'h22222222) in one frame -> single wr_ack; displayed nibbles all 2.
- wr_en of 32'h00000050 on the exact wrap cycle, blank_lz=1 -> committed immediately, wr_ack next cycle. seq_sel=1: an=FD, hex_nib=5. seq_sel=0: an=FE, hex_nib=0. seq_sel 2..7: an=FF.
- Same word, blank_lz=0, dp_in=8'h80 -> all 8 digits light. At seq_sel=7: hex_nib=0, dp_n=0.
- reset pulsed at seq_sel=5 with a pending write -> all outputs return to reset values asynchronously; no wr_ack; disp_reg=0 after release.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: scan FSM encoding,
// display geometry and the leading-zero blanking rule.
package seg_pkg;

  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  localparam int NUM_DIGITS = 8;
  localparam int SEL_W = 3;
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

  // Digit 0 always shows; a lit decimal point keeps a leading-zero digit visible.
  function automatic logic digit_blanked(input logic [4*NUM_DIGITS-1:0] word,
                                         input logic [NUM_DIGITS-1:0] dp,
                                         input logic [SEL_W-1:0] sel,
                                         input logic en);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(sel) && word[4*i +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return en && (sel != '0) && upper_zero && !dp[sel];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_div.sv
// Free-running divider: pxl_clk is a registered one-cycle tick every DIV_COUNT clocks.
module tick_div #(
  parameter int DIV_COUNT = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic pxl_clk
);

  localparam int CW = $clog2(DIV_COUNT);
  localparam logic [CW-1:0] LAST = CW'(DIV_COUNT - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pxl_clk <= 1'b0;
    end else begin
      pxl_clk <= (div_cnt == LAST);
      div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with a double-buffered
// display word committed at frame boundaries and optional leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIV_COUNT = 50000,
  parameter int GUARD     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic                    pxl_clk,
  output logic [SEL_W-1:0]        seq_sel,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              hex_nib,
  output logic                    dp_n,
  output logic                    wr_ack
);

  localparam int GW = $clog2(GUARD + 2);
  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  scan_state_t state, nxt_state;
  logic [GW-1:0]             guard_cnt, nxt_guard;
  logic [SEL_W-1:0]          nxt_sel;
  logic [4*NUM_DIGITS-1:0]   disp_reg, pend_word, nxt_disp;
  logic [NUM_DIGITS-1:0]     dp_reg, pend_dp, nxt_dp, nxt_an;
  logic                      pend_valid, commit;

  tick_div #(.DIV_COUNT(DIV_COUNT)) u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .pxl_clk (pxl_clk)
  );

  // Write handshake: wr_en is a one-cycle strobe that is always accepted (no
  // ready); the word waits in pend_* and wr_ack pulses once, the cycle after
  // the frame-wrap commit. Later strobes before that commit replace the word.
  always_comb begin
    nxt_state = state;
    nxt_guard = guard_cnt;
    nxt_sel   = seq_sel;
    commit    = 1'b0;
    if (pxl_clk) begin
      nxt_sel = seq_sel + SEL_W'(1);
      commit  = (seq_sel == LAST_SEL) && (pend_valid || wr_en);
      if (GUARD == 0) begin
        nxt_state = S_DRIVE;
        nxt_guard = '0;
      end else begin
        nxt_state = S_GUARD;
        nxt_guard = GUARD_LD;
      end
    end else if (state == S_GUARD) begin
      nxt_state = (guard_cnt <= GW'(1)) ? S_DRIVE : S_GUARD;
      nxt_guard = (guard_cnt != '0) ? guard_cnt - 1'b1 : '0;
    end

    nxt_disp = disp_reg;
    nxt_dp   = dp_reg;
    if (commit) begin
      nxt_disp = wr_en ? wr_data : pend_word;
      nxt_dp   = wr_en ? dp_in : pend_dp;
    end

    // Outputs are registered from next-state values so they line up with state.
    nxt_an = ANODES_OFF;
    if (nxt_state == S_DRIVE && !digit_blanked(nxt_disp, nxt_dp, nxt_sel, blank_lz))
      nxt_an[nxt_sel] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_GUARD;
      guard_cnt  <= GUARD_LD;
      seq_sel    <= '0;
      an         <= ANODES_OFF;
      hex_nib    <= '0;
      dp_n       <= 1'b1;
      wr_ack     <= 1'b0;
      disp_reg   <= '0;
      dp_reg     <= '0;
      pend_word  <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else begin
      state     <= nxt_state;
      guard_cnt <= nxt_guard;
      seq_sel   <= nxt_sel;
      disp_reg  <= nxt_disp;
      dp_reg    <= nxt_dp;
      an        <= nxt_an;
      hex_nib   <= nxt_disp[{nxt_sel, 2'b00} +: 4];
      dp_n      <= ~nxt_dp[nxt_sel];
      wr_ack    <= commit;
      if (commit) begin
        pend_valid <= 1'b0;
      end else if (wr_en) begin
        pend_word  <= wr_data;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-count based reference model, per-cycle compare,
// directed literal pins and randomized writes.
module tb_seg_scan_ctrl;

  localparam int DIV = 4;
  localparam int GRD = 1;
  localparam int W   = 32;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] wr_data = '0;
  logic [7:0]  dp_in = '0;
  logic        pxl_clk, dp_n, wr_ack;
  logic [2:0]  seq_sel;
  logic [7:0]  an;
  logic [3:0]  hex_nib;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV_COUNT(DIV), .GUARD(GRD)) dut (
    .clk      (clk),
    .reset    (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .pxl_clk  (pxl_clk),
    .seq_sel  (seq_sel),
    .an       (an),
    .hex_nib  (hex_nib),
    .dp_n     (dp_n),
    .wr_ack   (wr_ack)
  );

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // k = clock edges since reset release; everything else follows from k.
  int          k;
  logic [31:0] m_disp, m_pend;
  logic [7:0]  m_dp, m_pdp, m_an;
  bit          m_pv, m_pxl, m_ack, m_drive, m_dpn;
  int          m_sel;
  logic [3:0]  m_hex;

  function automatic int sel_after(input int j);
    if (j <= 0) return 0;
    return ((j - 1) / DIV) % 8;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit tick_used, commit, blanked;
    if (rst) begin
      k = 0; m_disp = '0; m_pend = '0; m_dp = '0; m_pdp = '0; m_pv = 0;
      m_pxl = 0; m_ack = 0; m_drive = 0; m_sel = 0; m_an = 8'hFF; m_hex = '0; m_dpn = 1;
    end else begin
      k++;
      tick_used = (k > DIV) && ((k - 1) % DIV == 0);
      commit = tick_used && (sel_after(k - 1) == 7) && (m_pv || wr_en);
      if (commit) begin
        m_disp = wr_en ? wr_data : m_pend;
        m_dp   = wr_en ? dp_in : m_pdp;
        m_pv   = 0;
        exp_q.push_back(m_disp);
      end else if (wr_en) begin
        m_pend = wr_data; m_pdp = dp_in; m_pv = 1;
      end
      m_ack = commit;
      m_sel = sel_after(k);
      m_pxl = (k % DIV == 0);
      m_drive = (k <= DIV) ? !(k < GRD) : !(((k - 1) % DIV) < GRD);
      blanked = blank_lz && (m_sel != 0) && ((m_disp >> (4 * m_sel)) == 0) && !m_dp[m_sel];
      m_an  = (!m_drive || blanked) ? 8'hFF : ~(8'h01 << m_sel);
      m_hex = m_disp[4*m_sel +: 4];
      m_dpn = ~m_dp[m_sel];
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  always @(negedge clk) begin
    logic [17:0] act, exp;
    if (!rst) begin
      act = {pxl_clk, seq_sel, an, hex_nib, dp_n, wr_ack};
      exp = {m_pxl, 3'(m_sel), m_an, m_hex, m_dpn, m_ack};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_cmp k=%0d got pxl/sel/an/hex/dpn/ack=%h expected %h", k, act, exp);
      end
      if (wr_ack === 1'b1) begin
        ack_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ack_q k=%0d got unexpected wr_ack expected none", k);
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int s, input bit drv);
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (m_sel == s && m_drive == drv) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_sel%0d: got timeout expected sel %0d within 400 cycles", s, s);
    end
  endtask

  task automatic wait_wrap_tick();
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (m_pxl && m_sel == 7) ok = 1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_wrap: got timeout expected wrap tick within 400 cycles");
    end
  endtask

  task automatic do_write(input logic [31:0] d, input logic [7:0] dp);
    wr_en = 1'b1; wr_data = d; dp_in = dp;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, a0;
    #12;
    check("reset_state", {pxl_clk, seq_sel, an, hex_nib, dp_n, wr_ack},
          {1'b0, 3'd0, 8'hFF, 4'h0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    // Idle scan, first tick latency
    n = 0;
    while (pxl_clk !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_tick", n, 4);
    repeat (40) @(negedge clk);

    // Mid-frame write, visible only after wrap
    wait_until(2, 1);
    do_write(32'h1234ABCD, 8'h01);
    check("pre_commit_hex", hex_nib, 4'h0);
    wait_until(0, 1);
    check("w1_sel0", {an, hex_nib, dp_n}, {8'hFE, 4'hD, 1'b0});
    wait_until(7, 1);
    check("w1_sel7", {an, hex_nib, dp_n}, {8'h7F, 4'h1, 1'b1});

    // Two writes in one frame: last wins, one ack
    wait_until(1, 1);
    a0 = ack_seen;
    do_write(32'h11111111, 8'h00);
    wait_until(3, 1);
    do_write(32'h22222222, 8'h00);
    wait_until(0, 1);
    wait_until(4, 1);
    check("double_write_acks", ack_seen - a0, 1);
    check("double_write_hex", hex_nib, 4'h2);

    // Write on the exact wrap cycle, blanking on
    blank_lz = 1'b1;
    a0 = ack_seen;
    wait_wrap_tick();
    do_write(32'h00000050, 8'h00);
    wait_until(0, 1);
    check("bypass_ack", ack_seen - a0, 1);
    check("lz_sel0", {an, hex_nib}, {8'hFE, 4'h0});
    wait_until(1, 1);
    check("lz_sel1", {an, hex_nib}, {8'hFD, 4'h5});
    for (int s = 2; s < 8; s++) begin
      wait_until(s, 1);
      check("lz_blank_an", an, 8'hFF);
    end

    // Same word, blanking off, dp on digit 7
    blank_lz = 1'b0;
    wait_until(2, 1);
    do_write(32'h00000050, 8'h80);
    wait_until(0, 1);
    wait_until(7, 1);
    check("nolz_sel7", {an, hex_nib, dp_n}, {8'h7F, 4'h0, 1'b0});

    // Randomized writes
    for (int c = 0; c < 700; c++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_data = $urandom >> (4 * $urandom_range(0, 7));
      dp_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
    end
    wr_en = 1'b0;
    repeat (40) @(negedge clk);

    // Async reset with a pending write
    wait_until(5, 1);
    do_write(32'hDEADBEEF, 8'hFF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", {pxl_clk, seq_sel, an, hex_nib, dp_n, wr_ack},
          {1'b0, 3'd0, 8'hFF, 4'h0, 1'b1, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    a0 = ack_seen;
    repeat (60) @(negedge clk);
    check("post_reset_acks", ack_seen - a0, 0);
    check("post_reset_hex", hex_nib, 4'h0);

    check("exp_q_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
